// File: rtl/blink_gen_if.sv
// blink_gen_if: configuration write bus for blink_gen.
interface blink_gen_if #(
  parameter int N_CH = 4,
  parameter int PW = 12,
  parameter int CW = 4
);
  localparam int CHW = N_CH > 1 ? $clog2(N_CH) : 1;
  logic cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [PW-1:0] cfg_period;
  logic [PW-1:0] cfg_on;
  logic [CW-1:0] cfg_count;
  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_on, cfg_count);
  modport slave (input cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_on, cfg_count);
endinterface

// File: rtl/blink_gen.sv
// blink_gen: multi-channel programmable blink generator with shared 1 ms prescaler.
// Defining BLINK_SYNC_EN adds a sync input that holds the prescaler and all phases at 0.
module blink_gen #(
  parameter int CLK_HZ = 100000000,
  parameter int N_CH = 4,
  parameter int PW = 12,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            reset,
`ifdef BLINK_SYNC_EN
  input  logic            sync,
`endif
  blink_gen_if.slave      cfg,
  output logic            ms_tick,
  output logic [N_CH-1:0] blink,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] done
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int DW = $clog2(DIV);
  localparam int CHW = N_CH > 1 ? $clog2(N_CH) : 1;
  typedef enum logic [1:0] {OFF, ON, BLINK, BURST} mode_t;
  logic hold;
`ifdef BLINK_SYNC_EN
  assign hold = sync;
`else
  assign hold = 1'b0;
`endif
  logic [DW-1:0] pre_q, pre_d;
  logic tick_q, tick_d;
  always_comb begin
    tick_d = !hold && pre_q == DW'(DIV - 1);
    pre_d = (hold || pre_q == DW'(DIV - 1)) ? '0 : pre_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      tick_q <= tick_d;
    end
  end
  assign ms_tick = tick_q;
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mode_t mode_q, mode_d;
    logic [PW-1:0] per_q, per_d, on_q, on_d, ph_q, ph_d, last;
    logic [CW-1:0] rem_q, rem_d;
    logic blink_q, blink_d, busy_q, busy_d, done_q, done_d, wr, run, wrap;
    assign wr = cfg.cfg_we && cfg.cfg_ch == CHW'(g);
    assign run = mode_q == BLINK || mode_q == BURST;
    // a zero period behaves as one, so the last phase is 0 in both cases
    assign last = per_q == '0 ? '0 : per_q - 1'b1;
    assign wrap = ph_q == last;
    always_comb begin
      mode_d = mode_q;
      per_d = per_q;
      on_d = on_q;
      ph_d = ph_q;
      rem_d = rem_q;
      done_d = 1'b0;
      if (wr) begin
        mode_d = mode_t'(cfg.cfg_mode);
        per_d = cfg.cfg_period;
        on_d = cfg.cfg_on;
        ph_d = '0;
        rem_d = cfg.cfg_count;
      end else if (mode_q == BURST && rem_q == '0) begin
        mode_d = OFF;
        done_d = 1'b1;
      end else if (hold) begin
        ph_d = '0;
      end else if (run && tick_q) begin
        ph_d = wrap ? '0 : ph_q + 1'b1;
        if (wrap && mode_q == BURST) begin
          rem_d = rem_q - 1'b1;
          mode_d = rem_q == CW'(1) ? OFF : mode_q;
          done_d = rem_q == CW'(1);
        end
      end
      busy_d = mode_d == BLINK || mode_d == BURST;
      blink_d = mode_d == ON || (busy_d && ph_d < on_d);
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mode_q <= OFF;
        per_q <= '0;
        on_q <= '0;
        ph_q <= '0;
        rem_q <= '0;
        blink_q <= 1'b0;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else begin
        mode_q <= mode_d;
        per_q <= per_d;
        on_q <= on_d;
        ph_q <= ph_d;
        rem_q <= rem_d;
        blink_q <= blink_d;
        busy_q <= busy_d;
        done_q <= done_d;
      end
    end
    assign blink[g] = blink_q;
    assign busy[g] = busy_q;
    assign done[g] = done_q;
  end
endmodule

// File: tb/tb_blink_gen.sv
// tb_blink_gen: directed checks of blink_gen at 10 cycles per ms.
module tb_blink_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ms_tick;
  logic [3:0] blink, busy, done;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  blink_gen_if #(.N_CH(4), .PW(12), .CW(4)) cfg_if ();
`ifdef BLINK_SYNC_EN
  logic sync = 1'b0;
`endif
  blink_gen #(.CLK_HZ(10000), .N_CH(4), .PW(12), .CW(4)) dut (
    .clk(clk),
    .reset(reset),
`ifdef BLINK_SYNC_EN
    .sync(sync),
`endif
    .cfg(cfg_if),
    .ms_tick(ms_tick),
    .blink(blink),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask
  task automatic run(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic wr(input int ch, input int mode, input int p, input int t, input int cnt);
    cfg_if.cfg_we = 1'b1;
    cfg_if.cfg_ch = 2'(ch);
    cfg_if.cfg_mode = 2'(mode);
    cfg_if.cfg_period = 12'(p);
    cfg_if.cfg_on = 12'(t);
    cfg_if.cfg_count = 4'(cnt);
    @(posedge clk);
    #1;
    cyc++;
    cfg_if.cfg_we = 1'b0;
  endtask
  initial begin
    cfg_if.cfg_we = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_mode = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_on = '0;
    cfg_if.cfg_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", 32'(ms_tick), 0);
    chk("rst_blink", 32'(blink), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    cyc = 0;
    run(9);  chk("tick_e9", 32'(ms_tick), 0);
    run(10); chk("tick_e10", 32'(ms_tick), 1);
    run(11); chk("tick_e11", 32'(ms_tick), 0);
    chk("idle_blink", 32'(blink), 0);
    chk("idle_busy", 32'(busy), 0);
    run(20); chk("tick_e20", 32'(ms_tick), 1);
    wr(0, 2, 4, 1, 0);
    chk("b0_start_blink", 32'(blink), 32'h1);
    chk("b0_start_busy", 32'(busy), 32'h1);
    run(30); chk("b0_hi_end", 32'(blink[0]), 1);
    run(31); chk("b0_lo_start", 32'(blink[0]), 0);
    run(60); chk("b0_lo_end", 32'(blink[0]), 0);
    run(61); chk("b0_hi_again", 32'(blink[0]), 1);
    run(71); chk("b0_lo_again", 32'(blink[0]), 0);
    run(80);
    wr(1, 3, 2, 1, 3);
    chk("burst_start_blink", 32'(blink), 32'h2);
    chk("burst_start_busy", 32'(busy), 32'h3);
    run(90);  chk("burst_p1_hi", 32'(blink[1]), 1);
    run(91);  chk("burst_p1_lo", 32'(blink[1]), 0);
    run(101); chk("burst_p2_hi", 32'(blink), 32'h3);
    run(140); chk("burst_pre_done", 32'(done), 0);
    chk("burst_pre_busy", 32'(busy), 32'h3);
    run(141); chk("burst_done", 32'(done), 32'h2);
    chk("burst_end_busy", 32'(busy), 32'h1);
    chk("burst_end_blink", 32'(blink), 32'h1);
    run(142); chk("burst_done_once", 32'(done), 0);
    wr(2, 3, 0, 0, 0);
    chk("cnt0_busy", 32'(busy), 32'h5);
    chk("cnt0_no_done_yet", 32'(done), 0);
    chk("cnt0_blink", 32'(blink[2]), 0);
    run(144); chk("cnt0_done", 32'(done), 32'h4);
    chk("cnt0_idle", 32'(busy), 32'h1);
    run(145); chk("cnt0_done_once", 32'(done), 0);
    wr(3, 2, 4, 5, 0);
    chk("t_ge_p_on", 32'(blink[3]), 1);
    wr(2, 2, 0, 0, 0);
    chk("p0t0_busy", 32'(busy), 32'hd);
    chk("p0t0_blink", 32'(blink[2]), 0);
    run(200);
    chk("mix_blink", 32'(blink), 32'h8);
    chk("mix_busy", 32'(busy), 32'hd);
    wr(1, 3, 2, 1, 3);
    chk("reburst_busy", 32'(busy[1]), 1);
    run(214);
    wr(1, 1, 0, 0, 0);
    chk("abort_on_blink", 32'(blink[1]), 1);
    chk("abort_busy", 32'(busy), 32'hd);
    for (int i = 0; i < 84; i++) begin
      run(cyc + 1);
      chk("abort_no_done", 32'(done), 0);
    end
    chk("abort_still_on", 32'(blink[1]), 1);
    reset = 1'b1;
    #1;
    chk("arst_tick", 32'(ms_tick), 0);
    chk("arst_blink", 32'(blink), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    run(5);
    chk("post_blink", 32'(blink), 0);
    chk("post_busy", 32'(busy), 0);
    run(9);  chk("post_tick_e9", 32'(ms_tick), 0);
    run(10); chk("post_tick_e10", 32'(ms_tick), 1);
    chk("post_off_blink", 32'(blink), 0);
    chk("post_off_busy", 32'(busy), 0);
    chk("post_off_done", 32'(done), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/blink_gen.md
# blink_gen

Multi-channel, runtime-programmable blink generator for the clock display, driving separator colons, alarm indicators and setting-mode digit flashing. A shared prescaler derives a 1 ms tick from the system clock. Each channel independently runs OFF, solid ON, continuous BLINK or a counted BURST with programmable period and on-time in milliseconds. Every timing-derived output is registered.

## Interface
- CLK_HZ, 100000000: system clock frequency in Hz; must be an integer multiple of 1000 and at least 2000.
- N_CH, 4: number of channels, 1..16.
- PW, 12: width of the period and on-time fields, in ms units (max 4095 ms).
- CW, 4: width of the burst count.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one cycle per write.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel; writes with cfg_ch >= N_CH are ignored.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_period  in  PW  period in ms.
- cfg_on  in  PW  on-time in ms.
- cfg_count  in  CW  number of BURST periods.
- ms_tick  out  1  one-cycle pulse every 1 ms.
- blink  out  N_CH  per-channel indicator output.
- busy  out  N_CH  high while a channel is in BLINK or BURST.
- done  out  N_CH  one-cycle pulse when a BURST completes.

## Operation
- Prescaler counts 0..CLK_HZ/1000-1 and wraps. ms_tick is registered and is high during the cycle after the prescaler reaches its terminal count.
- Per-channel state: mode, period P, on-time T, remaining bursts R, and phase counter 0..P-1.
- A write to channel c loads mode/P/T/R=cfg_count and sets phase=0. Other channels are unaffected.
- On each ms_tick, every BLINK or BURST channel advances its phase. At phase P-1 the phase wraps to 0.
- Output decode: OFF gives 0, ON gives 1. BLINK/BURST give 1 when phase < T.
- BURST: at each phase wrap R decrements. If that wrap takes R from 1 to 0, mode becomes OFF, done[c] pulses, and blink[c]=0.
- busy[c] = 1 iff mode is BLINK or BURST.
- Arithmetic: P=0 is treated as P=1. T >= P gives solid 1. T=0 gives solid 0, but phase still runs and BURST still completes.
- A BURST write with cfg_count=0 completes immediately: on the edge after the write, done pulses and mode becomes OFF.
- Write and ms_tick in the same cycle to the same channel: the write wins, phase=0, and that tick is not counted.
- Rewriting a busy channel restarts it. No done pulse is emitted for the aborted burst.
- Reset, at any time including mid-burst: prescaler=0, every mode=OFF, R=0, phase=0. ms_tick, blink, busy and done are all 0.

## Timing
- Config write sampled at rising edge k. blink, busy and mode reflect the new configuration from edge k, because blink is registered from next-state.
- ms_tick period is exactly CLK_HZ/1000 cycles; first pulse is CLK_HZ/1000 cycles after reset release.
- BLINK with (P, T): blink high for T ms, low for P-T ms, relative to ms_tick edges.
- BURST with R=n: blink goes low and busy drops in the same cycle as the done pulse, after exactly n·P ms_ticks counted after the write.
- done is a single-cycle pulse and never asserts for OFF/ON/BLINK channels.

## Configuration
- BLINK_SYNC_EN
  - Defined: adds input port sync (1 bit).
  - While sync is high: prescaler is held at 0, every channel's phase is held at 0, and ms_tick is 0. R and mode are unchanged.
  - This aligns all channels, for example on a seconds rollover.
  - A same-cycle cfg_we still loads its channel.
- Undefined: no sync port; phases are only restarted by writes and reset.

## Test plan
- Run with CLK_HZ=10000 (10 cycles/ms). Release reset: ms_tick pulses every 10 cycles; blink/busy/done stay 0 throughout.
- Write ch0 BLINK P=4 T=1: blink[0] high for 10 cycles, then low for 30 cycles, repeating. busy[0]=1.
- Write ch1 BURST P=2 T=1 count=3: exactly 3 high pulses. done[1] pulses once, 60 cycles after the write, with busy[1] and blink[1] falling in the same cycle.
- Corner-case writes, each on its own channel:
  - ch2 BURST count=0: done pulses on the next cycle.
  - ch3 BLINK T=5 P=4: blink solid 1.
  - BLINK P=0 T=0: blink solid 0, busy=1.
- Rewrite ch1 mid-burst with ON, then assert reset mid-BLINK: ch1 goes solid 1 with no done pulse. After reset, all outputs are 0 and every mode is OFF.
- With BLINK_SYNC_EN, two channels in BLINK P=4 T=2 are offset by 1 ms. Pulse sync for 3 cycles: both channels realign and toggle on identical cycles afterwards.
